// File: rtl/stack_port_master_pkg.sv
// Shared types and defaults for the LIFO stack port master.
package stack_port_master_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 1024;
    localparam int LEN_W_DEF  = 11;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PUSH = 3'd1,
        ST_TURN = 3'd2,
        ST_POP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/stack_port_master.sv
// Burst master for a LIFO stack's shared IO bus: push/pop bursts, bus turnaround,
// clean early stop on Full/Empty, and an advisory occupancy shadow.
module stack_port_master
    import stack_port_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err_full,
    output logic              err_empty,
    output logic [LEN_W-1:0]  remaining,
    output logic [LEN_W-1:0]  occupancy,
    inout  wire  [DATA_W-1:0] IO,
    output logic              Push_Pop,
    output logic              Enable,
    input  logic              Full,
    input  logic              Empty
);

    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] OCC_LIMIT = LEN_W'(DEPTH);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   occupancy_q, occupancy_d;
    logic               err_full_q, err_full_d;
    logic               err_empty_q, err_empty_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               drive_en;

    assign IO = drive_en ? wr_data : {DATA_W{1'bz}};

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign err_full  = err_full_q;
    assign err_empty = err_empty_q;
    assign remaining = remaining_q;
    assign occupancy = occupancy_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        occupancy_d = occupancy_q;
        err_full_d  = err_full_q;
        err_empty_d = err_empty_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        Enable      = 1'b0;
        Push_Pop    = 1'b1;
        drive_en    = 1'b0;
        done        = 1'b0;

        // Reset gates every combinational output so a mid-burst reset stops the bus at once.
        if (!Reset) begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        remaining_d = cmd_len;
                        err_full_d  = 1'b0;
                        err_empty_d = 1'b0;
                        if (cmd_len == '0)          state_d = ST_DONE;
                        else if (cmd_op == OP_PUSH) state_d = ST_PUSH;
                        else                        state_d = ST_TURN;
                    end
                end
                ST_PUSH: begin
                    Push_Pop = 1'b0;
                    drive_en = 1'b1;
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                    end else if (Full) begin
                        err_full_d = 1'b1;
                        state_d    = ST_DONE;
                    end else if (wr_valid) begin
                        Enable      = 1'b1;
                        wr_ready    = 1'b1;
                        remaining_d = remaining_q - LEN_ONE;
                        if (occupancy_q != OCC_LIMIT) occupancy_d = occupancy_q + LEN_ONE;
                        if (remaining_q == LEN_ONE) state_d = ST_DONE;
                    end
                end
                ST_TURN: begin
                    state_d = ST_POP;
                end
                ST_POP: begin
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                    end else if (Empty) begin
                        err_empty_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        Enable      = 1'b1;
                        rd_data_d   = IO;
                        rd_valid_d  = 1'b1;
                        remaining_d = remaining_q - LEN_ONE;
                        if (occupancy_q != '0) occupancy_d = occupancy_q - LEN_ONE;
                        if (remaining_q == LEN_ONE) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            occupancy_q <= '0;
            err_full_q  <= 1'b0;
            err_empty_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            occupancy_q <= occupancy_d;
            err_full_q  <= err_full_d;
            err_empty_q <= err_empty_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_stack_port_master.sv
// Self-checking bench: behavioural stack on the IO bus, command table plus corner sequences.
module tb_stack_port_master;
    import stack_port_master_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int LW    = 11;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, done, err_full, err_empty;
    logic [LW-1:0] remaining, occupancy;
    wire  [DW-1:0] IO;
    logic          Push_Pop, Enable, Full, Empty;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    stack_port_master #(.DATA_W(DW), .DEPTH(DEPTH), .LEN_W(LW)) dut (
        .Clk(Clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .err_full(err_full), .err_empty(err_empty),
        .remaining(remaining), .occupancy(occupancy),
        .IO(IO), .Push_Pop(Push_Pop), .Enable(Enable), .Full(Full), .Empty(Empty)
    );

    // Behavioural stack
    logic [DW-1:0] mem [DEPTH];
    int            sp = 0;
    logic [DW-1:0] top_word;
    logic          stk_drv;
    assign top_word = (sp != 0) ? mem[sp-1] : '0;
    assign stk_drv  = Enable && Push_Pop && (sp != 0);
    assign IO       = stk_drv ? top_word : {DW{1'bz}};
    assign Full     = (sp == DEPTH);
    assign Empty    = (sp == 0);

    always @(posedge Clk) begin
        if (Reset) sp <= 0;
        else if (Enable && !Push_Pop && sp < DEPTH) begin
            mem[sp] <= IO;
            sp      <= sp + 1;
        end else if (Enable && Push_Pop && sp > 0) sp <= sp - 1;
    end

    // Scoreboard queues: filled when a command is issued, drained by the monitor
    logic [DW-1:0] exp_push[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] ref_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (Enable && !Push_Pop) begin
                if (exp_push.size() == 0) chk("push_unexpected", 1, 0);
                else chk("push_data", int'(IO), int'(exp_push.pop_front()));
            end
            if (Full) chk("enable_while_full", int'(Enable && !Push_Pop), 0);
            if (rd_valid) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", int'(rd_data), int'(exp_rd.pop_front()));
            end
        end
    end

    typedef struct {
        logic          op;
        int            len;
        logic [DW-1:0] base;
        bit            stall;
        int            exp_rem;
        bit            exp_ef;
        bit            exp_ee;
        int            exp_occ;
        int            exp_xfer;
        int            exp_cyc;
    } vec_t;

    vec_t tbl[9];

    task automatic run_cmd(input vec_t v);
        int  en_cnt = 0;
        int  rd_cnt = 0;
        int  idx = 0;
        bit  got_done = 0;
        logic [DW-1:0] d;
        if (v.op == OP_PUSH) begin
            for (int i = 0; i < v.len; i++)
                if (ref_q.size() < DEPTH) begin
                    d = v.base + DW'(i);
                    exp_push.push_back(d);
                    ref_q.push_back(d);
                end
        end else begin
            for (int i = 0; i < v.len; i++)
                if (ref_q.size() > 0) exp_rd.push_back(ref_q.pop_back());
        end
        @(negedge Clk);
        chk("cmd_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_len = LW'(v.len); wr_valid = 1'b0;
        @(posedge Clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 3000 && !got_done; k++) begin
            wr_valid = (v.op == OP_PUSH) && !(v.stall && (k == 1 || k == 2));
            wr_data  = v.base + DW'(idx);
            @(negedge Clk);
            if (v.op == OP_PUSH && v.stall && (k == 1 || k == 2)) chk("stall_enable", int'(Enable), 0);
            if (v.op == OP_POP && k == 0) begin
                chk("turn_enable", int'(Enable), 0);
                chk("turn_pushpop", int'(Push_Pop), 1);
            end
            if (Enable) en_cnt++;
            if (rd_valid) rd_cnt++;
            if (wr_ready) idx++;
            if (done) begin
                got_done = 1;
                chk("remaining", int'(remaining), v.exp_rem);
                chk("err_full", int'(err_full), int'(v.exp_ef));
                chk("err_empty", int'(err_empty), int'(v.exp_ee));
                chk("occupancy", int'(occupancy), v.exp_occ);
                chk("transfers", (v.op == OP_PUSH) ? en_cnt : rd_cnt, v.exp_xfer);
                if (v.exp_cyc >= 0) chk("done_cycle", k, v.exp_cyc);
            end
            @(posedge Clk); #1;
        end
        wr_valid = 1'b0;
        if (!got_done) chk("done_timeout", 1, 0);
        chk("sb_drained", exp_push.size() + exp_rd.size(), 0);
    endtask

    initial begin
        //        op       len   base   stall rem ef ee occ  xfer cyc
        tbl[0] = '{OP_PUSH, 5,    8'h01, 0,    0,  0, 0, 5,    5,    5};
        tbl[1] = '{OP_POP,  5,    8'h00, 0,    0,  0, 0, 0,    5,    6};
        tbl[2] = '{OP_PUSH, 0,    8'hAA, 0,    0,  0, 0, 0,    0,    0};
        tbl[3] = '{OP_PUSH, 1,    8'h40, 0,    0,  0, 0, 1,    1,    1};
        tbl[4] = '{OP_POP,  3,    8'h00, 0,    2,  0, 1, 0,    1,    3};
        tbl[5] = '{OP_PUSH, 4,    8'h10, 1,    0,  0, 0, 4,    4,    6};
        tbl[6] = '{OP_POP,  4,    8'h00, 0,    0,  0, 0, 0,    4,    5};
        tbl[7] = '{OP_PUSH, 1030, 8'h00, 0,    6,  1, 0, 1024, 1024, 1025};
        tbl[8] = '{OP_POP,  1030, 8'h00, 0,    6,  0, 1, 0,    1024, 1026};

        Reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_enable", int'(Enable), 0);
        chk("rst_push_pop", int'(Push_Pop), 1);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) run_cmd(tbl[i]);

        // error flag is sticky past the one-cycle done strobe
        @(negedge Clk);
        chk("err_sticky", int'(err_empty), 1);
        chk("done_one_cycle", int'(done), 0);
        @(posedge Clk); #1;

        // Reset in the middle of a pop burst
        run_cmd('{OP_PUSH, 3, 8'h70, 0, 0, 0, 0, 3, 3, 3});
        @(negedge Clk);
        cmd_valid = 1'b1; cmd_op = OP_POP; cmd_len = LW'(3);
        @(posedge Clk); #1;
        cmd_valid = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("mid_rst_enable", int'(Enable), 0);
        chk("mid_rst_push_pop", int'(Push_Pop), 1);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 0);
        chk("mid_rst_wr_ready", int'(wr_ready), 0);
        chk("mid_rst_rd_valid", int'(rd_valid), 0);
        chk("mid_rst_rd_data", int'(rd_data), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_errs", int'({err_full, err_empty}), 0);
        chk("mid_rst_remaining", int'(remaining), 0);
        chk("mid_rst_occupancy", int'(occupancy), 0);
        exp_rd.delete(); exp_push.delete(); ref_q.delete();
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_cmd_ready", int'(cmd_ready), 1);
        chk("post_rst_done", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
